// File: rtl/operand_reg_file_pkg.sv
// Shared definitions for the operand register file and its clear sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package operand_reg_file_pkg;

   localparam int DW_DEF = 8;              // default data width, matches ALU operands
   localparam int AW_DEF = 4;              // default address width
   localparam int NREG   = 1 << AW_DEF;    // register count at default width

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CLEAR = 2'd1,
      DONE  = 2'd2
   } clr_state_t;

endpackage

// File: rtl/operand_reg_file_clear_sequencer.sv
// Clear sequencer: walks every register index once, issuing a zero-write per cycle.
// Latency: request sampled at edge t, CLEAR for 2**AW cycles, DONE one cycle, IDLE after t+2**AW+1.
// Backpressure: none; requests arriving while busy are dropped, not queued.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   clear_req       start a clear (sampled only in IDLE)
//   idle            FSM is in IDLE; gates architectural writes and flag updates
//   clear_we        zero-write strobe for clear_addr
//   clear_addr      index being zeroed this cycle
//   clear_busy      high in CLEAR and DONE
//   clear_done      high in DONE only
module operand_reg_file_clear_sequencer
   import operand_reg_file_pkg::*;
#(
   parameter int AW = AW_DEF
)
(
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clear_req,
   output logic          idle,
   output logic          clear_we,
   output logic [AW-1:0] clear_addr,
   output logic          clear_busy,
   output logic          clear_done
);

   clr_state_t    state, state_nxt;
   logic [AW-1:0] cnt, cnt_nxt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // All outputs decode the registered state only, so they cannot glitch
   // with input activity.
   always_comb begin
      state_nxt  = state;
      cnt_nxt    = cnt;
      idle       = 1'b0;
      clear_we   = 1'b0;
      clear_busy = 1'b0;
      clear_done = 1'b0;
      case (state)
         IDLE: begin
            idle = 1'b1;
            if (clear_req) begin
               state_nxt = CLEAR;
               cnt_nxt   = '0;
            end
         end
         CLEAR: begin
            clear_we   = 1'b1;
            clear_busy = 1'b1;
            // Counter wraps to 0 naturally after the last index.
            cnt_nxt    = cnt + 1'b1;
            if (cnt == {AW{1'b1}}) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            clear_busy = 1'b1;
            clear_done = 1'b1;
            state_nxt  = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   assign clear_addr = cnt;

endmodule

// File: rtl/operand_reg_file.sv
// Architectural register file feeding the ALU: 2 combinational read ports, 1 write port, Zero flag, hardware clear.
// Latency: reads 0 cycles (optional same-cycle forwarding); writes visible next cycle; clear takes 2**AW+1 busy cycles.
// Backpressure: none; writes and flag updates during a clear are dropped, ClearBusy tells the producer.
//
// Ports:
//   Clk, Reset_n            clock, asynchronous active-low reset
//   RaddrA/RaddrB           read addresses -> DataOutA/DataOutB (ALU InputA/InputB)
//   WriteEn, Waddr, DataIn  writeback port (ALU Out or load data)
//   ZeroIn, FlagEn          ALU Zero and its capture enable -> ZeroFlag
//   ClearReq                request zeroing of every register
//   ClearBusy, ClearDone    clear in progress / one-cycle completion pulse
module operand_reg_file
   import operand_reg_file_pkg::*;
#(
   parameter int DW      = DW_DEF,
   parameter int AW      = AW_DEF,
   parameter bit BYPASS  = 1'b1,
   parameter bit ZERO_R0 = 1'b0
)
(
   input  logic          Clk,
   input  logic          Reset_n,
   input  logic [AW-1:0] RaddrA,
   input  logic [AW-1:0] RaddrB,
   output logic [DW-1:0] DataOutA,
   output logic [DW-1:0] DataOutB,
   input  logic          WriteEn,
   input  logic [AW-1:0] Waddr,
   input  logic [DW-1:0] DataIn,
   input  logic          ZeroIn,
   input  logic          FlagEn,
   output logic          ZeroFlag,
   input  logic          ClearReq,
   output logic          ClearBusy,
   output logic          ClearDone
);

   localparam int NUM_REG = 1 << AW;

   logic [DW-1:0] rf [NUM_REG];
   logic          idle;
   logic          clear_we;
   logic [AW-1:0] clear_addr;
   logic          wr_acc;

   operand_reg_file_clear_sequencer #(
      .AW (AW)
   ) u_clear_sequencer (
      .clk        (Clk),
      .rst_n      (Reset_n),
      .clear_req  (ClearReq),
      .idle       (idle),
      .clear_we   (clear_we),
      .clear_addr (clear_addr),
      .clear_busy (ClearBusy),
      .clear_done (ClearDone)
   );

   // Writes only land in IDLE; with ZERO_R0 register 0 is never written,
   // which also keeps the bypass path from forwarding a write to r0.
   assign wr_acc = WriteEn && idle && !(ZERO_R0 && (Waddr == '0));

   // clear_we and wr_acc are mutually exclusive (CLEAR vs IDLE).
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         for (int i = 0; i < NUM_REG; i++) begin
            rf[i] <= '0;
         end
      end else if (clear_we) begin
         rf[clear_addr] <= '0;
      end else if (wr_acc) begin
         rf[Waddr] <= DataIn;
      end
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         ZeroFlag <= 1'b0;
      end else if (FlagEn && idle) begin
         ZeroFlag <= ZeroIn;
      end
   end

   // Hardwired-zero r0 takes priority over forwarding.
   always_comb begin
      DataOutA = rf[RaddrA];
      if (ZERO_R0 && (RaddrA == '0)) begin
         DataOutA = '0;
      end else if (BYPASS && wr_acc && (Waddr == RaddrA)) begin
         DataOutA = DataIn;
      end
   end

   always_comb begin
      DataOutB = rf[RaddrB];
      if (ZERO_R0 && (RaddrB == '0)) begin
         DataOutB = '0;
      end else if (BYPASS && wr_acc && (Waddr == RaddrB)) begin
         DataOutB = DataIn;
      end
   end

endmodule

// File: tb/tb_operand_reg_file.sv
// Directed bench for operand_reg_file: three instances (default, no-bypass, hardwired r0) share one stimulus.
// Latency: outputs sampled 1-2 time units after the rising edge.
// Backpressure: n/a.
module tb_operand_reg_file;

   logic       Clk;
   logic       Reset_n;
   logic [3:0] RaddrA, RaddrB, Waddr;
   logic [7:0] DataIn;
   logic       WriteEn, ZeroIn, FlagEn, ClearReq;

   logic [7:0] a_dut, b_dut, a_nb, b_nb, a_z, b_z;
   logic       zf_dut, zf_nb, zf_z;
   logic       busy_dut, busy_nb, busy_z;
   logic       done_dut, done_nb, done_z;

   int n_checks = 0;
   int n_errors = 0;

   operand_reg_file #(.DW(8), .AW(4), .BYPASS(1'b1), .ZERO_R0(1'b0)) dut (
      .Clk(Clk), .Reset_n(Reset_n), .RaddrA(RaddrA), .RaddrB(RaddrB),
      .DataOutA(a_dut), .DataOutB(b_dut), .WriteEn(WriteEn), .Waddr(Waddr),
      .DataIn(DataIn), .ZeroIn(ZeroIn), .FlagEn(FlagEn), .ZeroFlag(zf_dut),
      .ClearReq(ClearReq), .ClearBusy(busy_dut), .ClearDone(done_dut)
   );

   operand_reg_file #(.DW(8), .AW(4), .BYPASS(1'b0), .ZERO_R0(1'b0)) dut_nb (
      .Clk(Clk), .Reset_n(Reset_n), .RaddrA(RaddrA), .RaddrB(RaddrB),
      .DataOutA(a_nb), .DataOutB(b_nb), .WriteEn(WriteEn), .Waddr(Waddr),
      .DataIn(DataIn), .ZeroIn(ZeroIn), .FlagEn(FlagEn), .ZeroFlag(zf_nb),
      .ClearReq(ClearReq), .ClearBusy(busy_nb), .ClearDone(done_nb)
   );

   operand_reg_file #(.DW(8), .AW(4), .BYPASS(1'b1), .ZERO_R0(1'b1)) dut_z (
      .Clk(Clk), .Reset_n(Reset_n), .RaddrA(RaddrA), .RaddrB(RaddrB),
      .DataOutA(a_z), .DataOutB(b_z), .WriteEn(WriteEn), .Waddr(Waddr),
      .DataIn(DataIn), .ZeroIn(ZeroIn), .FlagEn(FlagEn), .ZeroFlag(zf_z),
      .ClearReq(ClearReq), .ClearBusy(busy_z), .ClearDone(done_z)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge Clk);
      #1;
   endtask

   int busy_cnt, done_cnt, done_at;

   initial begin
      Reset_n  = 1'b0;
      RaddrA   = '0;
      RaddrB   = '0;
      Waddr    = '0;
      DataIn   = '0;
      WriteEn  = 1'b0;
      ZeroIn   = 1'b0;
      FlagEn   = 1'b0;
      ClearReq = 1'b0;

      // ---- reset state
      repeat (2) tick();
      check_val("rst_busy", busy_dut, 0);
      check_val("rst_done", done_dut, 0);
      check_val("rst_zflag", zf_dut, 0);
      RaddrA = 4'd3; RaddrB = 4'd7; #1;
      check_val("rst_rdA", a_dut, 8'h00);
      check_val("rst_rdB", b_dut, 8'h00);
      Reset_n = 1'b1;
      tick();

      // ---- basic write/read
      WriteEn = 1'b1; Waddr = 4'd3; DataIn = 8'h5A;
      tick();
      Waddr = 4'd7; DataIn = 8'hA5;
      tick();
      WriteEn = 1'b0; RaddrA = 4'd3; RaddrB = 4'd7; #1;
      check_val("basic_rdA", a_dut, 8'h5A);
      check_val("basic_rdB", b_dut, 8'hA5);
      check_val("basic_nb_rdA", a_nb, 8'h5A);
      tick();

      // ---- bypass vs stored-only read
      WriteEn = 1'b1; Waddr = 4'd4; DataIn = 8'h3C; RaddrA = 4'd4; #1;
      check_val("byp_on", a_dut, 8'h3C);
      check_val("byp_off", a_nb, 8'h00);
      tick();
      WriteEn = 1'b0; #1;
      check_val("byp_off_next", a_nb, 8'h3C);
      tick();

      // ---- hardwired r0
      WriteEn = 1'b1; Waddr = 4'd0; DataIn = 8'hFF; RaddrA = 4'd0; #1;
      check_val("r0_wrcyc", a_z, 8'h00);
      check_val("r0_plain_byp", a_dut, 8'hFF);
      tick();
      WriteEn = 1'b0; #1;
      check_val("r0_after", a_z, 8'h00);
      check_val("r0_plain_after", a_dut, 8'hFF);
      tick();

      // ---- zero flag
      ZeroIn = 1'b1; FlagEn = 1'b1; #1;
      check_val("zf_not_yet", zf_dut, 0);
      tick();
      ZeroIn = 1'b0; FlagEn = 1'b0; #1;
      check_val("zf_set", zf_dut, 1);
      tick();
      check_val("zf_hold", zf_dut, 1);
      FlagEn = 1'b1;
      tick();
      FlagEn = 1'b0; #1;
      check_val("zf_clr", zf_dut, 0);

      // ---- clear sequence: preload r0..r14 = 0x11..0x1F, r15 = 0x10
      WriteEn = 1'b1;
      for (int i = 0; i < 16; i++) begin
         Waddr  = i[3:0];
         DataIn = 8'h10 + 8'(((i + 1) % 16));
         tick();
      end
      WriteEn = 1'b0;
      RaddrA = 4'd0; RaddrB = 4'd15; #1;
      check_val("pre_r0", a_dut, 8'h11);
      check_val("pre_r15", b_dut, 8'h10);
      tick();

      // request clear together with a write that must still commit
      ClearReq = 1'b1; WriteEn = 1'b1; Waddr = 4'd2; DataIn = 8'h77; RaddrA = 4'd2; #1;
      check_val("clr_req_byp", a_dut, 8'h77);
      tick();
      ClearReq = 1'b0; WriteEn = 1'b0;
      busy_cnt = 0; done_cnt = 0; done_at = 0;
      for (int c = 1; c <= 30; c++) begin
         if (busy_dut) busy_cnt++;
         if (done_dut) begin
            done_cnt++;
            done_at = c;
         end
         if (c == 1) begin
            #1;
            check_val("clr_wr_commit", a_dut, 8'h77);
         end
         if (c == 3) begin
            // r0, r1 zeroed so far; r2 not yet
            RaddrA = 4'd2; RaddrB = 4'd1; #1;
            check_val("clr_mid_r2", a_dut, 8'h77);
            check_val("clr_mid_r1", b_dut, 8'h00);
         end
         if (c == 10) begin
            // r5 already zeroed; this write and flag update must be dropped
            WriteEn = 1'b1; Waddr = 4'd5; DataIn = 8'h99; RaddrB = 4'd5;
            FlagEn = 1'b1; ZeroIn = 1'b1; #1;
            check_val("clr_no_byp", b_dut, 8'h00);
         end
         if (c == 11) begin
            WriteEn = 1'b0; FlagEn = 1'b0; ZeroIn = 1'b0;
         end
         tick();
      end
      check_val("clr_busy_cycles", busy_cnt, 17);
      check_val("clr_done_pulses", done_cnt, 1);
      check_val("clr_done_cycle", done_at, 17);
      check_val("clr_zflag_hold", zf_dut, 0);
      for (int i = 0; i < 16; i++) begin
         RaddrA = i[3:0]; #1;
         check_val($sformatf("clr_r%0d", i), a_dut, 8'h00);
         tick();
      end

      // ---- reset in the middle of a clear
      ZeroIn = 1'b1; FlagEn = 1'b1; WriteEn = 1'b1; Waddr = 4'd9; DataIn = 8'h99;
      tick();
      ZeroIn = 1'b0; FlagEn = 1'b0; Waddr = 4'd12; DataIn = 8'hC3;
      tick();
      WriteEn = 1'b0; #1;
      check_val("pre_rst_zflag", zf_dut, 1);
      ClearReq = 1'b1;
      tick();
      ClearReq = 1'b0;
      repeat (6) tick();      // clear index now 6
      check_val("mid_busy", busy_dut, 1);
      #2;
      Reset_n = 1'b0; #1;
      check_val("arst_busy", busy_dut, 0);
      check_val("arst_done", done_dut, 0);
      check_val("arst_zflag", zf_dut, 0);
      for (int i = 0; i < 16; i++) begin
         RaddrA = i[3:0]; #1;
         check_val($sformatf("arst_r%0d", i), a_dut, 8'h00);
      end
      @(negedge Clk);
      Reset_n = 1'b1;
      tick();
      WriteEn = 1'b1; Waddr = 4'd1; DataIn = 8'h42;
      tick();
      WriteEn = 1'b0; RaddrA = 4'd1; #1;
      check_val("post_rst_wr", a_dut, 8'h42);
      check_val("post_rst_busy", busy_dut, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/operand_reg_file.md
Name: operand_reg_file

Overview:
- Architectural register file directly upstream of the ALU.
- Two combinational read ports drive the ALU InputA/InputB operands.
- One clocked write port takes the writeback result, from ALU Out or load data.
- Also holds the architectural Zero flag (latched from ALU Zero) and a hardware clear sequencer that zeroes every register on request.

Parameters:
- DW, 8, data width; matches ALU operand width.
- AW, 4, address width; NREG = 2**AW registers.
- BYPASS, 1, 1 = same-cycle write-to-read forwarding; 0 = reads see stored value only.
- ZERO_R0, 0, 1 = register 0 always reads 0 and ignores writes.

Ports:
- Clk, input, 1, rising-edge clock.
- Reset_n, input, 1, asynchronous active-low reset.
- RaddrA, input, AW, read address, port A.
- RaddrB, input, AW, read address, port B.
- DataOutA, output, DW, operand A to ALU InputA.
- DataOutB, output, DW, operand B to ALU InputB.
- WriteEn, input, 1, write strobe.
- Waddr, input, AW, write address.
- DataIn, input, DW, write data.
- ZeroIn, input, 1, ALU Zero output.
- FlagEn, input, 1, capture ZeroIn into ZeroFlag this cycle.
- ZeroFlag, output, 1, registered Zero flag; drives branch decision.
- ClearReq, input, 1, request full-register clear.
- ClearBusy, output, 1, clear sequence in progress.
- ClearDone, output, 1, one-cycle pulse when clear completes.

Behaviour:
- Reset (Reset_n low, asynchronous):
  - all NREG registers = 0, ZeroFlag = 0;
  - FSM = IDLE, ClearBusy = 0, ClearDone = 0, clear counter = 0.
  - Release is sampled at the next rising edge.
- Reads are combinational, zero latency.
  - DataOutX = reg[RaddrX], except:
    - ZERO_R0=1 and RaddrX==0 -> 0;
    - otherwise BYPASS=1, write accepted this cycle, and Waddr==RaddrX -> DataIn.
  - The ZERO_R0 rule has priority over bypass.
- Write accepted when WriteEn=1, FSM=IDLE, and not (ZERO_R0=1 and Waddr==0).
  - reg[Waddr] <= DataIn at the rising edge; visible without bypass the following cycle.
- ZeroFlag <= ZeroIn at the rising edge when FlagEn=1 and FSM=IDLE; otherwise it holds.
- FSM states: IDLE, CLEAR, DONE.
- IDLE:
  - ClearReq=1 at an edge -> CLEAR, counter <= 0.
  - A write accepted in the same cycle as ClearReq still commits; the clear then zeroes it.
- CLEAR:
  - each edge: reg[counter] <= 0, counter++.
  - after writing index NREG-1 -> DONE; counter wraps to 0.
  - exactly NREG cycles in CLEAR.
- DONE: one cycle, then -> IDLE.
- Outputs by state:
  - ClearBusy = 1 in CLEAR and DONE; 0 in IDLE.
  - ClearDone = 1 only in DONE.
  - Both outputs are decoded from registered state, so they are glitch-free.
- During CLEAR/DONE:
  - WriteEn and FlagEn are ignored (dropped, not queued); ZeroFlag holds.
  - ClearReq is ignored.
  - Reads stay live and return the partially cleared contents.
  - Bypass is inactive because no write is accepted.
- ClearReq held high continuously: after DONE->IDLE, a new clear starts on the next edge.
- Reset mid-clear aborts the sequence; the result is identical to reset (all zero, IDLE).
- Total clear latency: ClearReq sampled at edge t; ClearBusy high from t through t+NREG+1; ClearDone high in the cycle after t+NREG.

Decomposition:
- Shared package (definitions):
  - DW/AW defaults;
  - enum clr_state_t {IDLE, CLEAR, DONE};
  - localparam NREG.
- One natural sub-module: clear_sequencer. It holds the FSM and counter, and outputs clear_we, clear_addr, ClearBusy, ClearDone.
- The register array, write-mux, and read/bypass logic stay in operand_reg_file.

Test Plan:
- Basic write/read, reset then write sequence:
  - write reg3=0x5A, reg7=0xA5 on consecutive cycles;
  - next cycle RaddrA=3, RaddrB=7 -> DataOutA=0x5A, DataOutB=0xA5.
- Bypass:
  - BYPASS=1: WriteEn=1, Waddr=4, DataIn=0x3C, RaddrA=4 same cycle -> DataOutA=0x3C combinationally.
  - BYPASS=0: same stimulus -> old value 0x00.
- ZERO_R0=1: write reg0=0xFF -> DataOutA with RaddrA=0 stays 0x00, in both the write cycle and after.
- Zero flag:
  - ZeroIn=1, FlagEn=1 -> ZeroFlag=1 next edge;
  - ZeroIn=0, FlagEn=0 -> holds 1;
  - ZeroIn=0, FlagEn=1 -> 0.
- Clear sequence:
  - load all 16 regs with 0x11..0x1F, 0x10;
  - pulse ClearReq alongside a write reg2=0x77;
  - ClearBusy high 17 cycles, ClearDone pulses once at cycle 17;
  - afterwards all regs read 0x00.
  - A WriteEn to reg5=0x99 and a FlagEn during busy have no effect.
- Reset mid-clear:
  - assert Reset_n=0 asynchronously mid-cycle at clear index 6 -> ClearBusy=0 immediately, ZeroFlag=0, all regs 0x00;
  - after release a normal write reg1=0x42 works.
